fc_layer5_engine: RTL

// - LeNet-5 layer 5 (C5) fully-connected stage, directly downstream of the C3/S4 middle layer.
// - Reads the 16x5x5 = 400 pooled S4 features from L4 output block memory; computes OUT_COUNT neurons.
// - Per neuron: bias + sum(feature*weight), ReLU, saturate, write to L5 output block memory.
// - One MAC per cycle, streaming addresses into synchronous-read BRAMs with fixed latency.
//

---
 rtl/fc_layer5_engine_pkg.sv | 19 +
 rtl/fc_layer5_engine_mac_unit.sv | 66 ++++++
 rtl/fc_layer5_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fc_layer5_engine_pkg.sv
// Shared constants and state encoding for the LeNet-5 C5 engine.
// Fixed-point format, saturation limit and one-hot FSM states.
package fc_layer5_engine_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int SAT_MAX    = (1 << (DATA_WIDTH - 1)) - 1;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_BIAS  = 6'b000010,
    S_MAC   = 6'b000100,
    S_DRAIN = 6'b001000,
    S_WRITE = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

endpackage

// File: rtl/fc_layer5_engine_mac_unit.sv
// Valid-gated signed MAC with bias load, ReLU and saturation.
// result reflects the accumulator value being written this cycle.
module fc_mac_unit
  import fc_layer5_engine_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic [DATA_WIDTH-1:0] feature,
  input  logic [DATA_WIDTH-1:0] weight,
  output logic [DATA_WIDTH-1:0] result
);

  logic [MEM_LATENCY-1:0]          vld;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [ACC_WIDTH-1:0]     acc_nxt;
  logic signed [ACC_WIDTH-1:0]     shifted;

  assign prod = $signed(feature) * $signed(weight);

  // next accumulator: bias load wins, else add product when read data is valid
  always_comb begin
    acc_nxt = acc;
    if (load) begin
      acc_nxt = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}},
                 bias, {FRAC_BITS{1'b0}}};
    end else if (vld[MEM_LATENCY-1]) begin
      acc_nxt = acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}},
                       prod};
    end
  end

  assign shifted = acc_nxt >>> FRAC_BITS;

  // ReLU then clamp to the largest positive data value
  always_comb begin
    result = shifted[DATA_WIDTH-1:0];
    if (shifted[ACC_WIDTH-1]) begin
      result = '0;
    end else if (shifted > SAT_MAX) begin
      result = DATA_WIDTH'(SAT_MAX);
    end
  end

  // accumulator and read-valid pipe; clear drops in-flight reads on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      vld <= '0;
    end else begin
      acc <= acc_nxt;
      if (clear) begin
        vld <= '0;
      end else begin
        vld <= (vld << 1) | MEM_LATENCY'(issue);
      end
    end
  end

endmodule

// File: rtl/fc_layer5_engine.sv
// LeNet-5 C5 fully-connected layer: one MAC per cycle over S4 features.
// FSM, counters and BRAM address generation; arithmetic in fc_mac_unit.
module fc_layer5_engine
  import fc_layer5_engine_pkg::*;
#(
  parameter int IN_COUNT    = 400,
  parameter int OUT_COUNT   = 120,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  L5_en,
  output logic [8:0]            L4_feature_addr,
  input  logic [DATA_WIDTH-1:0] L4_feature_dout,
  output logic [15:0]           L5_weight_addr,
  input  logic [DATA_WIDTH-1:0] L5_weight_dout,
  output logic [6:0]            L5_bias_addr,
  input  logic [DATA_WIDTH-1:0] L5_bias_dout,
  output logic [6:0]            L5_output_addr,
  output logic [DATA_WIDTH-1:0] L5_output_data,
  output logic                  L5_output_wea,
  output logic                  L5_busy,
  output logic                  L5_done
);

  localparam logic [8:0]  I_LAST    = 9'(IN_COUNT - 1);
  localparam logic [6:0]  N_LAST    = 7'(OUT_COUNT - 1);
  localparam logic [15:0] IN_STEP   = 16'(IN_COUNT);
  localparam logic [3:0]  CNT_BIAS  = 4'(MEM_LATENCY);
  localparam logic [3:0]  CNT_DRAIN = 4'(MEM_LATENCY - 1);

  state_t                state;
  logic [6:0]            n;
  logic [8:0]            i;
  logic [3:0]            cnt;
  logic [15:0]           base;
  logic                  wea_r;
  logic                  active;
  logic                  mac_load;
  logic [DATA_WIDTH-1:0] result;

  assign active   = !(state == S_IDLE || state == S_DONE);
  assign mac_load = (state == S_BIAS) && (cnt == CNT_BIAS) && L5_en;

  assign L5_busy       = active;
  assign L5_done       = (state == S_DONE);
  assign L5_output_wea = wea_r & L5_en;

  fc_mac_unit #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (active && !L5_en),
    .load   (mac_load),
    .issue  (state == S_MAC),
    .bias   (L5_bias_dout),
    .feature(L4_feature_dout),
    .weight (L5_weight_dout),
    .result (result)
  );

  // layer sequencing: bias fetch, streamed MAC, drain, write, next neuron
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      n               <= '0;
      i               <= '0;
      cnt             <= '0;
      base            <= '0;
      wea_r           <= 1'b0;
      L4_feature_addr <= '0;
      L5_weight_addr  <= '0;
      L5_bias_addr    <= '0;
      L5_output_addr  <= '0;
      L5_output_data  <= '0;
    end else begin
      wea_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (L5_en) begin
            state        <= S_BIAS;
            n            <= '0;
            base         <= '0;
            cnt          <= '0;
            L5_bias_addr <= '0;
          end
        end
        S_BIAS: begin
          if (!L5_en) begin
            state <= S_IDLE;
          end else if (cnt == CNT_BIAS) begin
            state           <= S_MAC;
            i               <= '0;
            L4_feature_addr <= '0;
            L5_weight_addr  <= base;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_MAC: begin
          if (!L5_en) begin
            state <= S_IDLE;
          end else if (i == I_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            i               <= i + 9'd1;
            L4_feature_addr <= i + 9'd1;
            L5_weight_addr  <= L5_weight_addr + 16'd1;
          end
        end
        S_DRAIN: begin
          if (!L5_en) begin
            state <= S_IDLE;
          end else if (cnt == CNT_DRAIN) begin
            state          <= S_WRITE;
            wea_r          <= 1'b1;
            L5_output_addr <= n;
            L5_output_data <= result;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WRITE: begin
          if (!L5_en) begin
            state <= S_IDLE;
          end else begin
            base <= base + IN_STEP;
            cnt  <= '0;
            if (n == N_LAST) begin
              state <= S_DONE;
            end else begin
              state        <= S_BIAS;
              n            <= n + 7'd1;
              L5_bias_addr <= n + 7'd1;
            end
          end
        end
        S_DONE: begin
          if (!L5_en) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
